// File: rtl/enc_stage2_round_if.sv
// enc_stage2_round_if: valid/ready word bus, upstream input side and downstream output side
interface enc_stage2_round_if;
  logic valid_in;
  logic [15:0] in_data;
  logic ready_out;
  logic [15:0] out_data;
  logic valid_out;
  logic ready_in;
  modport master(output valid_in, in_data, ready_in, input ready_out, out_data, valid_out);
  modport slave(input valid_in, in_data, ready_in, output ready_out, out_data, valid_out);
endinterface

// File: rtl/enc_stage2_round.sv
// enc_stage2_round: iterated key-xor / nibble S-box / rotate round stage, one word in flight
module enc_stage2_round #(
  parameter int ROUNDS = 4,
  parameter logic [15:0] KEY = 16'h3C5A
) (
  input logic clk,
  input logic rst,
  enc_stage2_round_if.slave bus
);
  localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, ROUND, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] st, st_n;
  logic [3:0] cnt, cnt_n;
  logic rdy, rdy_n, vld, vld_n;
  function automatic logic [3:0] sub(input logic [3:0] n);
    return SBOX[{4'd15 - n, 2'b00} +: 4];
  endfunction
  // upper half of the doubled key shifted left is the 16-bit left rotation
  function automatic logic [15:0] rnd(input logic [15:0] x, input logic [3:0] c);
    logic [31:0] kk;
    logic [15:0] t, s;
    kk = {KEY, KEY} << c;
    t = x ^ kk[31:16];
    s = {sub(t[15:12]), sub(t[11:8]), sub(t[7:4]), sub(t[3:0])};
    return {s[12:0], s[15:13]};
  endfunction
  always_comb begin
    state_n = state;
    st_n = st;
    cnt_n = cnt;
    rdy_n = rdy;
    vld_n = vld;
    unique case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (bus.valid_in && rdy) begin
          st_n = bus.in_data;
          cnt_n = '0;
          rdy_n = 1'b0;
          state_n = ROUND;
        end
      end
      ROUND: begin
        st_n = rnd(st, cnt);
        cnt_n = cnt + 4'd1;
        vld_n = cnt == LAST;
        state_n = cnt == LAST ? HOLD : ROUND;
      end
      HOLD: begin
        vld_n = !bus.ready_in;
        rdy_n = bus.ready_in;
        state_n = bus.ready_in ? IDLE : HOLD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      st <= '0;
      cnt <= '0;
      rdy <= 1'b0;
      vld <= 1'b0;
    end else begin
      state <= state_n;
      st <= st_n;
      cnt <= cnt_n;
      rdy <= rdy_n;
      vld <= vld_n;
    end
  assign bus.ready_out = rdy;
  assign bus.valid_out = vld;
  assign bus.out_data = st;
endmodule

// File: tb/tb_enc_stage2_round.sv
// tb_enc_stage2_round: scoreboard bench over ROUNDS=1/4/15 instances sharing one stimulus port
module tb_enc_stage2_round;
  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic clk = 0, rst = 1, vi = 0, ri = 0;
  logic [15:0] di = 0;
  int sel = 0, errs = 0, checks = 0, nout = 0, lat;
  logic [15:0] q [$];
  logic [15:0] last_d, p_od;
  logic p_vo = 0, p_ri = 0;
  logic ro, vo;
  logic [15:0] od;
  enc_stage2_round_if b0 ();
  enc_stage2_round_if b1 ();
  enc_stage2_round_if b2 ();
  enc_stage2_round #(.ROUNDS(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  enc_stage2_round #(.ROUNDS(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
  enc_stage2_round #(.ROUNDS(15)) u2 (.clk(clk), .rst(rst), .bus(b2));
  assign b0.valid_in = vi && sel == 0;
  assign b1.valid_in = vi && sel == 1;
  assign b2.valid_in = vi && sel == 2;
  assign b0.ready_in = ri && sel == 0;
  assign b1.ready_in = ri && sel == 1;
  assign b2.ready_in = ri && sel == 2;
  assign b0.in_data = di;
  assign b1.in_data = di;
  assign b2.in_data = di;
  assign ro = sel == 0 ? b0.ready_out : sel == 1 ? b1.ready_out : b2.ready_out;
  assign vo = sel == 0 ? b0.valid_out : sel == 1 ? b1.valid_out : b2.valid_out;
  assign od = sel == 0 ? b0.out_data : sel == 1 ? b1.out_data : b2.out_data;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic int rn(input int s);
    return s == 0 ? 1 : s == 1 ? 4 : 15;
  endfunction
  function automatic logic [15:0] mr(input logic [15:0] x, input int c);
    int kk;
    logic [15:0] t, s;
    kk = 32'h3C5A;
    t = x ^ 16'((kk << c) | (kk >> (16 - c)));
    for (int i = 0; i < 4; i++) s[4*i+:4] = SB[t[4*i+:4]];
    return {s[12:0], s[15:13]};
  endfunction
  function automatic logic [15:0] model(input logic [15:0] w, input int r);
    for (int c = 0; c < r; c++) w = mr(w, c);
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic send(input logic [15:0] w);
    int n = 0;
    vi = 1;
    di = w;
    while (!ro && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(ro), 1);
    @(negedge clk);
    q.push_back(model(w, rn(sel)));
    vi = 0;
    di = 16'($urandom);
  endtask
  task automatic recv(input int hold, output int l);
    int n = 0;
    logic [15:0] e;
    ri = 0;
    while (!vo && n < 60) begin
      @(negedge clk);
      n++;
    end
    l = n;
    chk("recv_valid", 32'(vo), 1);
    e = 16'hxxxx;
    if (q.size() != 0) e = q.pop_front();
    chk("recv_data", od, e);
    last_d = od;
    for (int h = 0; h < hold; h++) begin
      vi = 1;
      di = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(vo), 1);
      chk("hold_data", od, last_d);
      chk("hold_ready", 32'(ro), 0);
    end
    vi = 0;
    ri = 1;
    @(negedge clk);
    ri = 0;
    chk("hs_valid_low", 32'(vo), 0);
    chk("hs_ready_high", 32'(ro), 1);
  endtask
  task automatic step();
    logic [15:0] e;
    if (ro && vo) chk("ready_valid_excl", 32'(ro && vo), 0);
    if (p_vo && !p_ri) begin
      chk("stall_valid", 32'(vo), 1);
      chk("stall_data", od, p_od);
    end
    if (vi && ro) q.push_back(model(di, rn(sel)));
    if (vo && ri) begin
      e = 16'hxxxx;
      if (q.size() != 0) e = q.pop_front();
      chk("sb_data", od, e);
      nout++;
    end
    p_vo = vo;
    p_ri = ri;
    p_od = od;
    @(negedge clk);
  endtask
  initial begin
    int last_acc, nin;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ro), 0);
    chk("rst_valid", 32'(vo), 0);
    chk("rst_data", od, 0);
    vi = 1;
    di = 16'h0000;
    rst = 0;
    @(negedge clk);
    chk("first_edge_ready", 32'(ro), 1);
    send(16'h0000);
    recv(0, lat);
    chk("lat_r1", lat, 1);
    chk("r1_zero", last_d, 16'hA07D);
    send(16'hFFFF);
    recv(0, lat);
    chk("r1_ones", last_d, 16'h5F82);
    sel = 1;
    send(16'hBEEF);
    recv(10, lat);
    chk("lat_r4", lat, 4);
    ri = 1;
    vi = 1;
    last_acc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      di = 16'($urandom);
      if (ro) begin
        if (last_acc >= 0) chk("accept_gap", cyc - last_acc, 6);
        last_acc = cyc;
      end
      step();
    end
    vi = 0;
    repeat (10) step();
    chk("tput_drain", q.size(), 0);
    ri = 0;
    send(16'h5555);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_ready", 32'(ro), 0);
    chk("mid_rst_valid", 32'(vo), 0);
    chk("mid_rst_data", od, 0);
    q.delete();
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(vo), 0);
    rst = 0;
    @(negedge clk);
    chk("rel_ready", 32'(ro), 1);
    for (int i = 0; i < 8; i++) begin
      chk("no_ghost", 32'(vo), 0);
      @(negedge clk);
    end
    send(16'h0F0F);
    recv(0, lat);
    chk("post_rst_lat", lat, 4);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      nin = 0;
      nout = 0;
      p_vo = 0;
      for (int cyc = 0; cyc < 12000 && (nin < 333 || q.size() != 0); cyc++) begin
        ri = 1'($urandom);
        vi = nin < 333 && 1'($urandom);
        di = 16'($urandom);
        if (vi && ro) nin++;
        step();
      end
      vi = 0;
      ri = 0;
      chk("rand_drain", q.size(), 0);
      chk("rand_count", nout, 333);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
